fixed_point_accumulator: RTL and testbench

//  Streaming signed fixed-point accumulator (sfixWIDTH_EnFRAC) for neuron dot-product sums.

---
 rtl/fixed_point_accumulator.sv | 102 ++++++++++
 tb/tb_fixed_point_accumulator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_accumulator.sv
// Streaming signed fixed-point accumulator: sums operand packets delimited by in_last or MAX_TERMS.
// Build option: define SATURATE_EN to clamp out-of-range sums instead of wrapping them.
module fixed_point_accumulator #(
  parameter int unsigned WIDTH     = 26,
  parameter int unsigned FRAC      = 18,
  parameter int unsigned GUARD     = 10,
  parameter int unsigned MAX_TERMS = 784,
  localparam int unsigned CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  localparam int unsigned AW = WIDTH + GUARD;

  // The guard bits must cover the worst-case packet so the accumulator can never wrap.
  if (MAX_TERMS > 2 ** GUARD) begin : g_bad_guard
    $error("MAX_TERMS exceeds 2**GUARD; accumulator could wrap");
  end
  if (FRAC >= WIDTH) begin : g_bad_frac
    $error("FRAC must be smaller than WIDTH");
  end

  typedef enum logic {StAccum, StHold} state_e;

  state_e          state_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   sum;
  logic [GUARD:0]  sum_top;
  logic            sum_ovf;
  logic [WIDTH-1:0] narrow;
  logic            beat;
  logic            close;

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StHold);
  assign beat      = in_valid & in_ready;
  assign close     = beat & (in_last | (cnt_q == CW'(MAX_TERMS - 1)));

  always_comb begin
    sum     = acc_q + {{GUARD{in_data[WIDTH-1]}}, in_data};
    // Sum fits in WIDTH only if every bit from the WIDTH-1 sign position upward agrees.
    sum_top = sum[AW-1:WIDTH-1];
    sum_ovf = !((&sum_top) || !(|sum_top));
`ifdef SATURATE_EN
    if (sum_ovf) begin
      narrow = sum[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      narrow = sum[WIDTH-1:0];
    end
`else
    narrow = sum[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q   <= StAccum;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (close) begin
            out_data  <= narrow;
            out_count <= cnt_q + CW'(1);
            out_ovf   <= sum_ovf;
            out_trunc <= ~in_last;
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= StHold;
          end else if (beat) begin
            acc_q <= sum;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator: two instances (MAX_TERMS 784 and 4) on shared inputs,
// checked every cycle against an integer packet model plus directed literal expectations.
module tb_fixed_point_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [25:0] in_data = '0;

  logic        in_ready_a [2];
  logic        out_valid_a [2];
  logic [25:0] out_data_a [2];
  logic        ovf_a [2];
  logic        trunc_a [2];
  logic [9:0]  out_count_0;
  logic [2:0]  out_count_1;
  logic [9:0]  cnt_a [2];

  assign cnt_a[0] = out_count_0;
  assign cnt_a[1] = {7'b0, out_count_1};

  always #5 clk = ~clk;

  fixed_point_accumulator #(.WIDTH(26), .FRAC(18), .GUARD(10), .MAX_TERMS(784)) u_dut0 (
    .clk(clk), .GlobalReset(rst_n), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a[0]), .out_ready(out_ready),
    .out_data(out_data_a[0]), .out_count(out_count_0), .out_ovf(ovf_a[0]),
    .out_trunc(trunc_a[0])
  );

  fixed_point_accumulator #(.WIDTH(26), .FRAC(18), .GUARD(10), .MAX_TERMS(4)) u_dut1 (
    .clk(clk), .GlobalReset(rst_n), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a[1]), .out_ready(out_ready),
    .out_data(out_data_a[1]), .out_count(out_count_1), .out_ovf(ovf_a[1]),
    .out_trunc(trunc_a[1])
  );

  // Packet model: plain integer sums and counts per instance.
  longint      m_sum [2];
  int          m_cnt [2];
  logic        m_hold [2];
  logic [25:0] e_data [2];
  int          e_count [2];
  logic        e_ovf [2];
  logic        e_trunc [2];

  int n_tests = 0;
  int n_fail = 0;

  function automatic int max_terms(int i);
    return (i == 0) ? 784 : 4;
  endfunction

  function automatic logic out_of_range(longint s);
    return (s > 64'sd33554431) || (s < -64'sd33554432);
  endfunction

  function automatic logic [25:0] narrow_of(longint s);
`ifdef SATURATE_EN
    if (s > 64'sd33554431) return 26'h1FFFFFF;
    if (s < -64'sd33554432) return 26'h2000000;
`endif
    return 26'(s);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_sum[i]  <= 0;
        m_cnt[i]  <= 0;
        m_hold[i] <= 1'b0;
      end else if (!m_hold[i]) begin
        if (in_valid) begin
          if (in_last || (m_cnt[i] + 1 == max_terms(i))) begin
            m_hold[i]  <= 1'b1;
            e_data[i]  <= narrow_of(m_sum[i] + longint'($signed(in_data)));
            e_ovf[i]   <= out_of_range(m_sum[i] + longint'($signed(in_data)));
            e_count[i] <= m_cnt[i] + 1;
            e_trunc[i] <= !in_last;
            m_sum[i]   <= 0;
            m_cnt[i]   <= 0;
          end else begin
            m_sum[i] <= m_sum[i] + longint'($signed(in_data));
            m_cnt[i] <= m_cnt[i] + 1;
          end
        end
      end else if (out_ready) begin
        m_hold[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("in_ready[%0d]", i), longint'(in_ready_a[i]), longint'(!m_hold[i]));
          chk($sformatf("out_valid[%0d]", i), longint'(out_valid_a[i]), longint'(m_hold[i]));
          if (m_hold[i]) begin
            chk($sformatf("out_data[%0d]", i), longint'(out_data_a[i]), longint'(e_data[i]));
            chk($sformatf("out_count[%0d]", i), longint'(cnt_a[i]), longint'(e_count[i]));
            chk($sformatf("out_ovf[%0d]", i), longint'(ovf_a[i]), longint'(e_ovf[i]));
            chk($sformatf("out_trunc[%0d]", i), longint'(trunc_a[i]), longint'(e_trunc[i]));
          end
        end
      end
    end
  endtask

  task automatic send(input int inst, input logic [25:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready_a[inst] && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input int inst, input logic [25:0] d, input int cnt, input logic ov,
                         input logic tr);
    int t = 0;
    while (!out_valid_a[inst] && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("collect_valid", longint'(out_valid_a[inst]), 1);
    chk("lit_data", longint'(out_data_a[inst]), longint'(d));
    chk("lit_count", longint'(cnt_a[inst]), longint'(cnt));
    chk("lit_ovf", longint'(ovf_a[inst]), longint'(ov));
    chk("lit_trunc", longint'(trunc_a[inst]), longint'(tr));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, longint'(out_valid_a[0]), 0);
    chk({tag, "_out_data"}, longint'(out_data_a[0]), 0);
    chk({tag, "_out_count"}, longint'(cnt_a[0]), 0);
    chk({tag, "_out_ovf"}, longint'(ovf_a[0]), 0);
    chk({tag, "_out_trunc"}, longint'(trunc_a[0]), 0);
    chk({tag, "_in_ready"}, longint'(in_ready_a[0]), 1);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset low for two cycles, then release.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Test 1: -2 + 1 = -1, result visible the cycle after the last beat.
    send(0, 26'h3FFFFFE, 1'b0);
    send(0, 26'h0000001, 1'b1);
    chk("t1_latency_valid", longint'(out_valid_a[0]), 1);
    collect(0, 26'h3FFFFFF, 2, 1'b0, 1'b0);

    // Test 2: max positive + 1 overflows.
    send(0, 26'h1FFFFFF, 1'b0);
    send(0, 26'h0000001, 1'b1);

    // Test 3: stall the result for five cycles with a pending operand offered.
    in_valid = 1'b1;
    in_data  = 26'h0000003;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t3_in_ready_low", longint'(in_ready_a[0]), 0);
      chk("t3_valid_held", longint'(out_valid_a[0]), 1);
    end
    in_valid = 1'b0;
`ifdef SATURATE_EN
    chk("t2_data", longint'(out_data_a[0]), longint'(26'h1FFFFFF));
`else
    chk("t2_data", longint'(out_data_a[0]), longint'(26'h2000000));
`endif
    chk("t2_ovf", longint'(ovf_a[0]), 1);
    chk("t2_count", longint'(cnt_a[0]), 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t3_in_ready_back", longint'(in_ready_a[0]), 1);
    chk("t3_valid_drop", longint'(out_valid_a[0]), 0);

    // Clean start for both instances.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 4: MAX_TERMS=4 instance truncates a 6-beat stream of 1.0.
    repeat (4) send(1, 26'h0040000, 1'b0);
    collect(1, 26'h0100000, 4, 1'b0, 1'b1);
    send(1, 26'h0040000, 1'b0);
    send(1, 26'h0040000, 1'b1);
    collect(1, 26'h0080000, 2, 1'b0, 1'b0);

    // Test 5: reset mid-packet discards the partial sum; outputs clear at once.
    repeat (3) send(0, 26'h0000009, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 26'h0000005, 1'b0);
    send(0, 26'h0000007, 1'b1);
    collect(0, 26'h000000C, 2, 1'b0, 1'b0);

    // Test 6: full-length packet of -1.
    for (int k = 0; k < 784; k++) send(0, 26'h3FFFFFF, (k == 783));
    collect(0, 26'h3FFFCF0, 784, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
